pc_unit: RTL and testbench
==========================

PC_UNIT -- requirements
Module: pc_unit

Interface
REQ-001 Parameter XLEN, 32: PC/address width.
REQ-002 Parameter RESET_VECTOR, 0: PC loaded on reset.
REQ-003 Parameter TRAP_VECTOR, 32'h0000_0100: PC loaded on misaligned-target trap.
REQ-004 Parameter C_EXT, 0: 1 enables 2-byte instruction alignment and PC+2 sequencing.
REQ-005 clk  in  1  single clock, rising edge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 pc_ready  in  1  instruction memory accepts current pc.
REQ-008 stall  in  1  hold PC, no decision taken.
REQ-009 is_compressed  in  1  current instruction is 16-bit (ignored when C_EXT=0).
REQ-010 branch_type  in  4  branch_t: NONE, JAL, JALR, BEQ, BNE, BLT, BGE, BLTU, BGEU.
REQ-011 offset  in  XLEN  branch/JAL offset, signed.
REQ-012 target_pc  in  XLEN  JALR computed target.
REQ-013 alu_zero, alu_neg, alu_ltu  in  1 each  compare flags: equal, signed less-than, unsigned less-than.
REQ-014 pc  out  XLEN  current fetch address.
REQ-015 pc_valid  out  1  pc is a valid fetch request.
REQ-016 return_pc  out  XLEN  pc + inc (link value).
REQ-017 trap_valid  out  1  one-cycle misaligned-target trap pulse.
REQ-018 trap_addr  out  XLEN  offending target, valid with trap_valid.

Function
REQ-019 fire = pc_valid & pc_ready & ~stall; the PC and FSM shall advance only on fire, except TRAP->RUN and BOOT->RUN, which are unconditional.
REQ-020 inc = 2 when C_EXT=1 and is_compressed=1, else 4; all PC arithmetic modulo 2^XLEN (wrap, no flag).
REQ-021 taken: JAL, JALR always; BEQ zero; BNE ~zero; BLT neg; BGE ~neg; BLTU ltu; BGEU ~ltu; NONE never; undefined codes treated as NONE.
REQ-022 Target: JALR = target_pc with bit0 cleared; other taken types = pc + offset; not taken = pc + inc.
REQ-023 Misaligned: taken target with bit1 set when C_EXT=0, or bit0 set when C_EXT=1 (non-JALR only).
REQ-024 FSM states BOOT, RUN, TRAP; BOOT: pc_valid=0, -> RUN next cycle.
REQ-025 RUN: pc_valid=1; on fire with aligned target pc<=target; on fire with misaligned target pc<=TRAP_VECTOR, trap_addr<=target, -> TRAP.
REQ-026 TRAP: pc_valid=0, trap_valid=1 for exactly one cycle, all inputs ignored, -> RUN.
REQ-027 Stall or pc_ready=0 in RUN: pc, state and trap outputs hold; branch inputs re-evaluated on the eventual fire cycle.
REQ-028 return_pc combinational from current pc and is_compressed in every state.

Reset
REQ-029 rst high at a rising edge shall override all activity, including mid-trap: pc=RESET_VECTOR, state=BOOT, pc_valid=0, trap_valid=0, trap_addr=0.
REQ-030 The first fetch shall present pc=RESET_VECTOR with pc_valid=1 in the second cycle after rst deasserts.

Structure
REQ-031 Package pc_pkg shall hold branch_t enum, pc_state_t enum, and default parameter constants.
REQ-032 Taken-condition logic shall be one combinational sub-module, branch_eval (branch_type, flags -> taken).
REQ-033 Registers: pc, state, trap_addr only; no latches.

Verification
REQ-034 Reset/boot: rst 1 cycle, RESET_VECTOR=0 -> cycle 1 pc_valid=0, cycle 2 pc=0 pc_valid=1; NONE x3 with pc_ready=1 -> pc 4, 8, 12.
REQ-035 Branches: pc=0x40, BEQ offset=-8, alu_zero=1 -> pc=0x38; BNE alu_zero=1 -> 0x44; BGEU alu_ltu=0 offset=0x10 -> pc+0x10.
REQ-036 JALR: target_pc=0x203 -> pc=0x202 with C_EXT=1; with C_EXT=0 -> pc=TRAP_VECTOR, trap_valid one cycle, trap_addr=0x202, pc_valid=0 that cycle.
REQ-037 Stall/handshake: BLT taken held while stall=1 for 3 cycles, then pc_ready=0 for 2 cycles -> pc unchanged 5 cycles, jumps on first fire.
REQ-038 Compressed and wrap: C_EXT=1, pc=0xFFFF_FFFE, is_compressed=1, NONE -> pc=0, return_pc shown as 0 beforehand.
REQ-039 Reset in TRAP state -> next cycle pc=RESET_VECTOR, trap_valid=0, state BOOT.

Source files
------------

// File: rtl/pc_pkg.sv
// Shared types and default constants for the program-counter unit.
// Latency: none (declarations only).
// Backpressure: not applicable.
package pc_pkg;

    localparam int          XLEN_DEF         = 32;
    localparam logic [31:0] RESET_VECTOR_DEF = 32'h0000_0000;
    localparam logic [31:0] TRAP_VECTOR_DEF  = 32'h0000_0100;
    localparam bit          C_EXT_DEF        = 1'b0;

    typedef enum logic [3:0] {
        BR_NONE = 4'd0,
        BR_JAL  = 4'd1,
        BR_JALR = 4'd2,
        BR_BEQ  = 4'd3,
        BR_BNE  = 4'd4,
        BR_BLT  = 4'd5,
        BR_BGE  = 4'd6,
        BR_BLTU = 4'd7,
        BR_BGEU = 4'd8
    } branch_t;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_TRAP = 2'd2
    } pc_state_t;

endpackage

// File: rtl/pc_unit_branch_eval.sv
// Branch-taken decision from branch type and ALU compare flags.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the result is consumed.
// Ports: branch_type (4-bit code), alu_zero/alu_neg/alu_ltu flags -> taken.
module branch_eval
    import pc_pkg::*;
(
    input  logic [3:0] branch_type,
    input  logic       alu_zero,
    input  logic       alu_neg,
    input  logic       alu_ltu,
    output logic       taken
);

    always_comb begin
        taken = 1'b0;
        case (branch_t'(branch_type))
            BR_JAL, BR_JALR: taken = 1'b1;
            BR_BEQ:          taken = alu_zero;
            BR_BNE:          taken = ~alu_zero;
            BR_BLT:          taken = alu_neg;
            BR_BGE:          taken = ~alu_neg;
            BR_BLTU:         taken = alu_ltu;
            BR_BGEU:         taken = ~alu_ltu;
            // NONE and any unassigned code fall through as not taken
            default:         taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/pc_unit.sv
// Program counter with branch/jump sequencing and misaligned-target trap.
// Latency: next PC registered one cycle after a fire; trap pulse lasts one cycle.
// Backpressure: PC and state hold while stall=1 or pc_ready=0 in RUN.
// Ports: clk/rst; pc_ready, stall, is_compressed, branch_type, offset,
//        target_pc, alu flags in; pc, pc_valid, return_pc, trap_valid,
//        trap_addr out.
module pc_unit
    import pc_pkg::*;
#(
    parameter int               XLEN         = XLEN_DEF,
    parameter logic [XLEN-1:0]  RESET_VECTOR = XLEN'(RESET_VECTOR_DEF),
    parameter logic [XLEN-1:0]  TRAP_VECTOR  = XLEN'(TRAP_VECTOR_DEF),
    parameter bit               C_EXT        = C_EXT_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            pc_ready,
    input  logic            stall,
    input  logic            is_compressed,
    input  logic [3:0]      branch_type,
    input  logic [XLEN-1:0] offset,
    input  logic [XLEN-1:0] target_pc,
    input  logic            alu_zero,
    input  logic            alu_neg,
    input  logic            alu_ltu,
    output logic [XLEN-1:0] pc,
    output logic            pc_valid,
    output logic [XLEN-1:0] return_pc,
    output logic            trap_valid,
    output logic [XLEN-1:0] trap_addr
);

    pc_state_t       state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] trap_addr_q, trap_addr_d;

    logic [XLEN-1:0] inc;
    logic [XLEN-1:0] target;
    logic            taken;
    logic            is_jalr;
    logic            misaligned;
    logic            fire;

    branch_eval u_branch_eval (
        .branch_type (branch_type),
        .alu_zero    (alu_zero),
        .alu_neg     (alu_neg),
        .alu_ltu     (alu_ltu),
        .taken       (taken)
    );

    assign inc     = (C_EXT && is_compressed) ? XLEN'(2) : XLEN'(4);
    assign is_jalr = (branch_type == BR_JALR);

    // JALR clears bit0 of its target, so the C_EXT bit0 check can never
    // fire for it; only the C_EXT=0 bit1 check matters for JALR.
    always_comb begin
        target = pc_q + inc;
        if (taken) begin
            target = is_jalr ? {target_pc[XLEN-1:1], 1'b0} : (pc_q + offset);
        end
    end

    assign misaligned = taken && (C_EXT ? target[0] : target[1]);

    assign pc         = pc_q;
    assign pc_valid   = (state_q == ST_RUN);
    assign trap_valid = (state_q == ST_TRAP);
    assign trap_addr  = trap_addr_q;
    assign return_pc  = pc_q + inc;
    assign fire       = pc_valid & pc_ready & ~stall;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        trap_addr_d = trap_addr_q;
        case (state_q)
            ST_BOOT: state_d = ST_RUN;
            ST_RUN: begin
                if (fire) begin
                    if (misaligned) begin
                        pc_d        = TRAP_VECTOR;
                        trap_addr_d = target;
                        state_d     = ST_TRAP;
                    end else begin
                        pc_d = target;
                    end
                end
            end
            // Trap cycle ignores every input and always resumes fetching.
            ST_TRAP: state_d = ST_RUN;
            default: state_d = ST_BOOT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_BOOT;
            pc_q        <= RESET_VECTOR;
            trap_addr_q <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            trap_addr_q <= trap_addr_d;
        end
    end

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: one C_EXT=0 and one C_EXT=1 instance on shared inputs.
// Latency: outputs compared every negedge against a behavioural model.
// Backpressure: stall and pc_ready exercised by directed vectors.
module tb_pc_unit;
    import pc_pkg::*;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, pc_ready, stall, is_c;
    logic [3:0]  bt;
    logic [31:0] offset, target_pc;
    logic        zf, nf, lf;

    logic [31:0] pc0, rpc0, ta0, pc1, rpc1, ta1;
    logic        pv0, tv0, pv1, tv1;

    pc_unit #(.XLEN(32), .RESET_VECTOR(32'h0), .TRAP_VECTOR(32'h100), .C_EXT(1'b0)) dut0 (
        .clk(clk), .rst(rst), .pc_ready(pc_ready), .stall(stall), .is_compressed(is_c),
        .branch_type(bt), .offset(offset), .target_pc(target_pc),
        .alu_zero(zf), .alu_neg(nf), .alu_ltu(lf),
        .pc(pc0), .pc_valid(pv0), .return_pc(rpc0), .trap_valid(tv0), .trap_addr(ta0)
    );

    pc_unit #(.XLEN(32), .RESET_VECTOR(32'h0), .TRAP_VECTOR(32'h100), .C_EXT(1'b1)) dut1 (
        .clk(clk), .rst(rst), .pc_ready(pc_ready), .stall(stall), .is_compressed(is_c),
        .branch_type(bt), .offset(offset), .target_pc(target_pc),
        .alu_zero(zf), .alu_neg(nf), .alu_ltu(lf),
        .pc(pc1), .pc_valid(pv1), .return_pc(rpc1), .trap_valid(tv1), .trap_addr(ta1)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic chkb(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%b required=%b", name, act, exp);
        end
    endtask

    // Behavioural model: index 0 is the C_EXT=0 instance, index 1 the C_EXT=1 one.
    bit          m_known = 1'b0;
    bit          m_boot [2];
    bit          m_trap [2];
    logic [31:0] m_pc   [2];
    logic [31:0] m_ta   [2];

    // Conditional types come in (flag, inverted flag) pairs: BEQ/BNE on zero,
    // BLT/BGE on neg, BLTU/BGEU on ltu.
    function automatic bit model_taken(input logic [3:0] b, input bit z, input bit n, input bit l);
        bit flags [3];
        int k;
        if (b == 4'd1 || b == 4'd2) return 1'b1;
        if (b < 4'd3 || b > 4'd8) return 1'b0;
        flags[0] = z; flags[1] = n; flags[2] = l;
        k = int'(b) - 3;
        return flags[k / 2] ^ (k % 2 == 1);
    endfunction

    function automatic logic [31:0] step_of(input int idx, input logic c);
        return (idx == 1 && c) ? 32'd2 : 32'd4;
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            logic [31:0] dest;
            bit          tk;
            if (rst) begin
                m_pc[i] = 32'h0; m_boot[i] = 1'b1; m_trap[i] = 1'b0; m_ta[i] = 32'h0;
            end else if (!m_known) begin
                // nothing known before the first reset
            end else if (m_boot[i]) begin
                m_boot[i] = 1'b0;
            end else if (m_trap[i]) begin
                m_trap[i] = 1'b0;
            end else if (pc_ready && !stall) begin
                tk = model_taken(bt, zf, nf, lf);
                if (!tk)              dest = m_pc[i] + step_of(i, is_c);
                else if (bt == 4'd2)  dest = target_pc & ~32'd1;
                else                  dest = m_pc[i] + offset;
                if (tk && ((i == 1) ? dest[0] : dest[1])) begin
                    m_ta[i] = dest; m_pc[i] = 32'h100; m_trap[i] = 1'b1;
                end else begin
                    m_pc[i] = dest;
                end
            end
        end
        if (rst) m_known = 1'b1;
    end

    always @(negedge clk) begin
        if (m_known) begin
            chk ("m_pc0",   pc0,  m_pc[0]);
            chkb("m_pv0",   pv0,  !m_boot[0] && !m_trap[0]);
            chkb("m_tv0",   tv0,  m_trap[0]);
            chk ("m_ta0",   ta0,  m_ta[0]);
            chk ("m_rpc0",  rpc0, m_pc[0] + step_of(0, is_c));
            chk ("m_pc1",   pc1,  m_pc[1]);
            chkb("m_pv1",   pv1,  !m_boot[1] && !m_trap[1]);
            chkb("m_tv1",   tv1,  m_trap[1]);
            chk ("m_ta1",   ta1,  m_ta[1]);
            chk ("m_rpc1",  rpc1, m_pc[1] + step_of(1, is_c));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; pc_ready = 1'b1; stall = 1'b0; is_c = 1'b0;
        bt = BR_NONE; offset = 32'h0; target_pc = 32'h0; zf = 1'b0; nf = 1'b0; lf = 1'b0;

        // Reset and boot
        tick();
        chk ("rst_pc", pc0, 32'h0);
        chkb("rst_pv", pv0, 1'b0);
        chkb("rst_tv", tv0, 1'b0);
        chk ("rst_ta", ta0, 32'h0);
        rst = 1'b0;
        tick();
        chkb("boot_pv", pv0, 1'b1);
        chk ("boot_pc", pc0, 32'h0);
        tick(); chk("seq_4",  pc0, 32'd4);
        tick(); chk("seq_8",  pc0, 32'd8);
        tick(); chk("seq_12", pc0, 32'd12);

        // Branches around 0x40
        bt = BR_JAL; offset = 32'h34; tick(); chk("jal_40", pc0, 32'h40);
        bt = BR_BEQ; offset = 32'hFFFF_FFF8; zf = 1'b1; tick(); chk("beq_38", pc0, 32'h38);
        bt = BR_JAL; offset = 32'h8; zf = 1'b0; tick(); chk("jal_40b", pc0, 32'h40);
        bt = BR_BNE; offset = 32'hFFFF_FFF8; zf = 1'b1; tick(); chk("bne_44", pc0, 32'h44);
        bt = BR_BGEU; zf = 1'b0; lf = 1'b0; offset = 32'h10; tick(); chk("bgeu_54", pc0, 32'h54);
        bt = BR_NONE; #1; chk("rpc_58", rpc0, 32'h58);

        // JALR to 0x203: aligned for C_EXT=1, trap for C_EXT=0
        bt = BR_JALR; target_pc = 32'h203; tick();
        chk ("jalr_trap_pc", pc0, 32'h100);
        chkb("jalr_trap_tv", tv0, 1'b1);
        chkb("jalr_trap_pv", pv0, 1'b0);
        chk ("jalr_trap_ta", ta0, 32'h202);
        chk ("jalr_c_pc",    pc1, 32'h202);
        chkb("jalr_c_tv",    tv1, 1'b0);
        // Trap cycle ignores the JAL presented here
        bt = BR_JAL; offset = 32'h1000; tick();
        chkb("trap_end_tv", tv0, 1'b0);
        chkb("trap_end_pv", pv0, 1'b1);
        chk ("trap_end_pc", pc0, 32'h100);
        chk ("jal_c_pc",    pc1, 32'h1202);

        // Stall 3 cycles, then pc_ready low 2 cycles, BLT taken throughout
        bt = BR_BLT; nf = 1'b1; offset = 32'h20; stall = 1'b1;
        repeat (3) begin tick(); chk("stall_hold", pc0, 32'h100); end
        stall = 1'b0; pc_ready = 1'b0;
        repeat (2) begin tick(); chk("rdy_hold", pc0, 32'h100); end
        pc_ready = 1'b1; tick();
        chk("blt_fire0", pc0, 32'h120);
        chk("blt_fire1", pc1, 32'h1222);
        nf = 1'b0;

        // Compressed wrap on C_EXT=1; same JALR traps on C_EXT=0
        bt = BR_JALR; target_pc = 32'hFFFF_FFFE; tick();
        chk ("wrap_setup1", pc1, 32'hFFFF_FFFE);
        chkb("wrap_trap0",  tv0, 1'b1);
        chk ("wrap_ta0",    ta0, 32'hFFFF_FFFE);
        bt = BR_NONE; is_c = 1'b1; #1;
        chk("wrap_rpc1", rpc1, 32'h0);
        chk("nc_rpc0",   rpc0, 32'h104);
        tick();
        chk("wrap_pc1", pc1, 32'h0);
        chk("resume_pc0", pc0, 32'h100);
        is_c = 1'b0;

        // Undefined code behaves as NONE
        bt = 4'hF; offset = 32'h80; tick(); chk("undef_pc0", pc0, 32'h104);

        // Conditional types across flag patterns; the model checks each cycle
        for (int v = 0; v < 12; v++) begin
            bt = 4'(3 + (v % 6));
            zf = v[0]; nf = v[1]; lf = v[2];
            offset = 32'h10;
            tick();
        end

        // Reset while in TRAP
        bt = BR_JAL; offset = 32'h2; zf = 1'b0; nf = 1'b0; lf = 1'b0; tick();
        chkb("pre_rst_tv", tv0, 1'b1);
        rst = 1'b1; bt = BR_NONE; tick();
        chk ("trst_pc", pc0, 32'h0);
        chkb("trst_tv", tv0, 1'b0);
        chkb("trst_pv", pv0, 1'b0);
        chk ("trst_ta", ta0, 32'h0);
        rst = 1'b0; tick();
        chkb("trst_run_pv", pv0, 1'b1);
        chk ("trst_run_pc", pc0, 32'h0);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
